trap_seq_ctrl: RTL and testbench
================================

// Module: trap_seq_ctrl
// PURPOSE
// Trap/return sequencer owning the single-port machine CSR file. Accepts retiring
// ECALL/EBREAK/MRET/illegal events and the timer interrupt, then performs the
// mepc/mcause/mstatus updates and mtvec/mepc read over several cycles.
// Also arbitrates that one CSR port against normal core CSR read/write traffic,
// and emits the PC redirect to the fetch unit.
// PARAMETERS
// XLEN        32            data / PC width
// TIMER_CAUSE 32'h8000_0007 mcause written for a machine timer interrupt
// RESET_MIE   1'b0          reset value of the internal mstatus.MIE shadow
// PORTS
// clk            in   1     clock; all state on posedge
// rst            in   1     synchronous, active-high reset
// inst_valid     in   1     retiring instruction present
// inst_ready     out  1     =1 iff state==IDLE; handshake = inst_valid&inst_ready
// inst_kind      in   3     0 NONE,1 MRET,2 ECALL,3 EBREAK,4 ILLEGAL; others = NONE
// inst_pc        in   XLEN  PC of retiring instruction
// irq_timer      in   1     level timer interrupt request
// core_csr_wen   in   1     core CSR write request (csrrw etc.)
// core_csr_addr  in   12    core CSR address (read and write)
// core_csr_wdata in   XLEN  core CSR write data
// core_csr_rdata out  XLEN  CSR read data returned to core
// csr_wen        out  1     CSR file write enable
// csr_addr       out  12    CSR file address (shared read/write)
// csr_wdata      out  XLEN  CSR file write data
// csr_rdata      in   XLEN  CSR file combinational read data
// squash         out  1     1-cycle: accepted instruction must not commit
// redirect_valid out  1     1-cycle: fetch must jump to redirect_pc
// redirect_pc    out  XLEN  redirect target
// busy           out  1     =1 iff state!=IDLE; front end stalls
// halt           out  1     sticky after EBREAK until rst
// BEHAVIOUR
// States: IDLE, WR_EPC, WR_CAUSE, WR_STAT, RD_VEC, RD_EPC, RET_STAT, REDIR, HALT.
// Reset: state IDLE, mie=RESET_MIE, mpie=0, epc/cause/target regs 0; all outputs 0
//  except inst_ready=1; rst mid-sequence aborts it with no further CSR writes.
// IDLE: CSR port = core (csr_wen/addr/wdata pass through, core_csr_rdata=csr_rdata).
//  Core write to 0x300 also updates shadows mie<=wdata[3], mpie<=wdata[7].
// Non-IDLE: core_csr_wen ignored, core_csr_rdata=0; sequencer drives the port.
// On handshake in IDLE (priority high->low):
//  irq_timer&mie: squash=1, epc<=inst_pc, cause<=TIMER_CAUSE -> WR_EPC
//  ECALL: epc<=inst_pc, cause<=11 -> WR_EPC;  ILLEGAL: cause<=2 -> WR_EPC
//  EBREAK -> HALT;  MRET -> RD_EPC;  NONE: stay IDLE, no action.
// Interrupt sampled only on a handshake cycle; no retiring instruction, no irq.
// WR_EPC: wen, addr 0x341, data epc -> WR_CAUSE (wen, 0x342, cause) -> WR_STAT:
//  wen, 0x300, data {19'b0,2'b11,3'b0,mie,3'b0,0,3'b0}; mpie<=mie, mie<=0 -> RD_VEC.
// RD_VEC: addr 0x305, target<=csr_rdata&~3 -> REDIR.
// RD_EPC: addr 0x341, target<=csr_rdata -> RET_STAT: wen, 0x300, MPP=11,
//  MPIE=1, MIE=mpie; mie<=mpie, mpie<=1 -> REDIR.
// REDIR: redirect_valid=1, redirect_pc=target -> IDLE. Trap latency: handshake T,
//  redirect at T+5; MRET: redirect at T+3. redirect_pc=0 outside REDIR.
// HALT: halt=1, busy=1, no CSR writes, leave only by rst.
// csr_wen=0 in every state not listed as writing.
// TESTING
// rst, then ECALL at pc 0x8000_0100, mtvec=0x8000_0203 -> wen 0x341/0x8000_0100,
//  0x342/11, 0x300/0x1800 on T+1..T+3; redirect_pc 0x8000_0200 at T+5.
// Core write 0x300=0x8, irq_timer=1, ADD at 0x8000_0040 -> squash T, mcause
//  0x8000_0007, mepc 0x8000_0040, status write 0x1880.
// Then MRET with mepc=0x8000_0044 -> status write 0x1888, redirect to
//  0x8000_0044 at T+3, mie shadow=1 again.
// irq_timer=1 with mie=0 and ECALL -> ECALL path, no squash, mcause 11.
// Core csr write arriving while busy -> csr_wen stays 0 for it; no lost trap write.
// EBREAK -> halt=1, busy=1, inst_ready=0 indefinitely; rst at T+2 of a trap
//  sequence -> IDLE next cycle, csr_wen=0, redirect_valid never asserted.

Source files
------------

// File: rtl/trap_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_seq_ctrl
// Brief    : Trap/return sequencer that owns the single-port machine CSR file
//            and arbitrates it against core CSR traffic.
// Revision : 1.0 - initial release
// ============================================================================
module trap_seq_ctrl #(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] TIMER_CAUSE = 32'h8000_0007,
    parameter logic            RESET_MIE   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inst_valid,
    output logic            inst_ready,
    input  logic [2:0]      inst_kind,
    input  logic [XLEN-1:0] inst_pc,
    input  logic            irq_timer,
    input  logic            core_csr_wen,
    input  logic [11:0]     core_csr_addr,
    input  logic [XLEN-1:0] core_csr_wdata,
    output logic [XLEN-1:0] core_csr_rdata,
    output logic            csr_wen,
    output logic [11:0]     csr_addr,
    output logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            squash,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            busy,
    output logic            halt
);

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_WR_EPC   = 4'd1;
    localparam logic [3:0] c_WR_CAUSE = 4'd2;
    localparam logic [3:0] c_WR_STAT  = 4'd3;
    localparam logic [3:0] c_RD_VEC   = 4'd4;
    localparam logic [3:0] c_RD_EPC   = 4'd5;
    localparam logic [3:0] c_RET_STAT = 4'd6;
    localparam logic [3:0] c_REDIR    = 4'd7;
    localparam logic [3:0] c_HALT     = 4'd8;

    localparam logic [2:0] c_KIND_MRET    = 3'd1;
    localparam logic [2:0] c_KIND_ECALL   = 3'd2;
    localparam logic [2:0] c_KIND_EBREAK  = 3'd3;
    localparam logic [2:0] c_KIND_ILLEGAL = 3'd4;

    localparam logic [11:0] c_ADDR_MSTATUS = 12'h300;
    localparam logic [11:0] c_ADDR_MTVEC   = 12'h305;
    localparam logic [11:0] c_ADDR_MEPC    = 12'h341;
    localparam logic [11:0] c_ADDR_MCAUSE  = 12'h342;

    logic [3:0]      r_state;
    logic [3:0]      w_state_nxt;
    logic            r_mie;
    logic            r_mpie;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_cause;
    logic [XLEN-1:0] r_target;
    logic            w_hs;
    logic            w_irq_take;
    logic [XLEN-1:0] w_stat_trap;
    logic [XLEN-1:0] w_stat_ret;

    assign w_hs       = inst_valid && (r_state == c_IDLE);
    assign w_irq_take = irq_timer && r_mie;

    // mstatus images: MPP=11 in both; trap saves MIE into MPIE, return restores it
    assign w_stat_trap = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, r_mie, 7'b0};
    assign w_stat_ret  = {{(XLEN-13){1'b0}}, 2'b11, 3'b000, 1'b1, 3'b000, r_mpie, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_IDLE;
            r_mie    <= RESET_MIE;
            r_mpie   <= 1'b0;
            r_epc    <= '0;
            r_cause  <= '0;
            r_target <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                c_IDLE: begin
                    if (core_csr_wen && (core_csr_addr == c_ADDR_MSTATUS)) begin
                        r_mie  <= core_csr_wdata[3];
                        r_mpie <= core_csr_wdata[7];
                    end
                    if (w_hs) begin
                        if (w_irq_take) begin
                            r_epc   <= inst_pc;
                            r_cause <= TIMER_CAUSE;
                        end else if (inst_kind == c_KIND_ECALL) begin
                            r_epc   <= inst_pc;
                            r_cause <= XLEN'(11);
                        end else if (inst_kind == c_KIND_ILLEGAL) begin
                            r_epc   <= inst_pc;
                            r_cause <= XLEN'(2);
                        end
                    end
                end
                c_WR_STAT: begin
                    r_mpie <= r_mie;
                    r_mie  <= 1'b0;
                end
                c_RD_VEC:   r_target <= {csr_rdata[XLEN-1:2], 2'b00};
                c_RD_EPC:   r_target <= csr_rdata;
                c_RET_STAT: begin
                    r_mie  <= r_mpie;
                    r_mpie <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        inst_ready     = 1'b0;
        busy           = 1'b1;
        halt           = 1'b0;
        squash         = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        csr_wen        = 1'b0;
        csr_addr       = '0;
        csr_wdata      = '0;
        core_csr_rdata = '0;
        case (r_state)
            c_IDLE: begin
                inst_ready     = 1'b1;
                busy           = 1'b0;
                csr_wen        = core_csr_wen;
                csr_addr       = core_csr_addr;
                csr_wdata      = core_csr_wdata;
                core_csr_rdata = csr_rdata;
                if (w_hs) begin
                    // a pending enabled interrupt preempts whatever is retiring
                    if (w_irq_take) begin
                        squash      = 1'b1;
                        w_state_nxt = c_WR_EPC;
                    end else begin
                        case (inst_kind)
                            c_KIND_ECALL, c_KIND_ILLEGAL: w_state_nxt = c_WR_EPC;
                            c_KIND_EBREAK:                w_state_nxt = c_HALT;
                            c_KIND_MRET:                  w_state_nxt = c_RD_EPC;
                            default:                      w_state_nxt = c_IDLE;
                        endcase
                    end
                end
            end
            c_WR_EPC: begin
                csr_wen     = 1'b1;
                csr_addr    = c_ADDR_MEPC;
                csr_wdata   = r_epc;
                w_state_nxt = c_WR_CAUSE;
            end
            c_WR_CAUSE: begin
                csr_wen     = 1'b1;
                csr_addr    = c_ADDR_MCAUSE;
                csr_wdata   = r_cause;
                w_state_nxt = c_WR_STAT;
            end
            c_WR_STAT: begin
                csr_wen     = 1'b1;
                csr_addr    = c_ADDR_MSTATUS;
                csr_wdata   = w_stat_trap;
                w_state_nxt = c_RD_VEC;
            end
            c_RD_VEC: begin
                csr_addr    = c_ADDR_MTVEC;
                w_state_nxt = c_REDIR;
            end
            c_RD_EPC: begin
                csr_addr    = c_ADDR_MEPC;
                w_state_nxt = c_RET_STAT;
            end
            c_RET_STAT: begin
                csr_wen     = 1'b1;
                csr_addr    = c_ADDR_MSTATUS;
                csr_wdata   = w_stat_ret;
                w_state_nxt = c_REDIR;
            end
            c_REDIR: begin
                redirect_valid = 1'b1;
                redirect_pc    = r_target;
                w_state_nxt    = c_IDLE;
            end
            c_HALT: begin
                halt        = 1'b1;
                w_state_nxt = c_HALT;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_trap_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_seq_ctrl
// Brief    : Randomized scoreboard bench for trap_seq_ctrl with a transaction-
//            level model of the trap/return rules and an attached CSR file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_valid;
    logic        inst_ready;
    logic [2:0]  inst_kind;
    logic [31:0] inst_pc;
    logic        irq_timer;
    logic        core_csr_wen;
    logic [11:0] core_csr_addr;
    logic [31:0] core_csr_wdata;
    logic [31:0] core_csr_rdata;
    logic        csr_wen;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        squash;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        busy;
    logic        halt;

    always #5 clk = ~clk;

    trap_seq_ctrl #(
        .XLEN        (32),
        .TIMER_CAUSE (32'h8000_0007),
        .RESET_MIE   (1'b0)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_kind      (inst_kind),
        .inst_pc        (inst_pc),
        .irq_timer      (irq_timer),
        .core_csr_wen   (core_csr_wen),
        .core_csr_addr  (core_csr_addr),
        .core_csr_wdata (core_csr_wdata),
        .core_csr_rdata (core_csr_rdata),
        .csr_wen        (csr_wen),
        .csr_addr       (csr_addr),
        .csr_wdata      (csr_wdata),
        .csr_rdata      (csr_rdata),
        .squash         (squash),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
        .halt           (halt)
    );

    // event kinds seen by the monitor
    localparam int c_EV_WR  = 0;
    localparam int c_EV_RED = 1;
    localparam int c_EV_SQ  = 2;

    typedef struct {
        int          cyc;
        int          kind;
        logic [11:0] addr;
        logic [31:0] data;
    } evt_t;

    evt_t        exp_q[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fails = 0;
    bit          mon_en = 1'b0;
    int          next_free = 0;
    bit          m_mie = 1'b0;
    bit          m_mpie = 1'b0;
    logic [31:0] mdl_csr [0:4] = '{default: '0};
    logic [31:0] env_mem [0:4] = '{default: '0};

    function automatic int aidx(input logic [11:0] a);
        case (a)
            12'h300: return 0;
            12'h305: return 1;
            12'h341: return 2;
            12'h342: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic logic [11:0] rand_addr();
        case ($urandom_range(0, 4))
            0:       return 12'h300;
            1:       return 12'h305;
            2:       return 12'h341;
            3:       return 12'h342;
            default: return 12'h340;
        endcase
    endfunction

    // Environment CSR file: combinational read, written by whatever the DUT drives
    assign csr_rdata = env_mem[aidx(csr_addr)];
    always @(posedge clk) if (csr_wen === 1'b1) env_mem[aidx(csr_addr)] <= csr_wdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_evt(input int c, input int k, input logic [11:0] a, input logic [31:0] d);
        evt_t e;
        e.cyc = c; e.kind = k; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic match(input int k, input logic [11:0] a, input logic [31:0] d);
        evt_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fails++;
            $display("FAIL unexpected_event: kind %0d addr %h data %h at cycle %0d", k, a, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.kind != k || e.addr !== a || e.data !== d) begin
                n_fails++;
                $display("FAIL event_match: got kind %0d addr %h data %h cycle %0d, expected kind %0d addr %h data %h cycle %0d",
                         k, a, d, cyc, e.kind, e.addr, e.data, e.cyc);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                n_checks++;
                n_fails++;
                $display("FAIL missed_event: kind %0d addr %h data %h due cycle %0d, absent at cycle %0d",
                         exp_q[0].kind, exp_q[0].addr, exp_q[0].data, exp_q[0].cyc, cyc);
                void'(exp_q.pop_front());
            end
            if (squash === 1'b1)         match(c_EV_SQ, 12'h0, 32'h0);
            if (csr_wen === 1'b1)        match(c_EV_WR, csr_addr, csr_wdata);
            if (redirect_valid === 1'b1) match(c_EV_RED, 12'h0, redirect_pc);
            else                         chk("redirect_pc_idle", redirect_pc, 32'h0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        inst_valid     = 1'b0;
        inst_kind      = 3'd0;
        inst_pc        = 32'h0;
        irq_timer      = 1'b0;
        core_csr_wen   = 1'b0;
        core_csr_addr  = 12'h0;
        core_csr_wdata = 32'h0;
    endtask

    task automatic junk();
        inst_valid     = 1'($urandom_range(0, 1));
        inst_kind      = 3'($urandom_range(0, 7));
        inst_pc        = $urandom();
        irq_timer      = 1'($urandom_range(0, 1));
        core_csr_wen   = 1'($urandom_range(0, 1));
        core_csr_addr  = rand_addr();
        core_csr_wdata = $urandom();
    endtask

    // Step to the next cycle the model says the sequencer can accept work,
    // filling the busy window with quiet, random or write-heavy traffic.
    task automatic advance(input int mode);
        tick();
        while (cyc < next_free) begin
            if (mode == 0) quiet();
            else junk();
            if (mode == 2) core_csr_wen = 1'b1;
            tick();
        end
    endtask

    task automatic do_core_write(input logic [11:0] a, input logic [31:0] d);
        quiet();
        core_csr_wen   = 1'b1;
        core_csr_addr  = a;
        core_csr_wdata = d;
        push_evt(cyc, c_EV_WR, a, d);
        mdl_csr[aidx(a)] = d;
        if (a == 12'h300) begin
            m_mie  = d[3];
            m_mpie = d[7];
        end
        next_free = cyc + 1;
    endtask

    task automatic do_core_read(input logic [11:0] a);
        quiet();
        core_csr_addr = a;
        next_free = cyc + 1;
        @(negedge clk);
        chk("core_csr_rdata", core_csr_rdata, mdl_csr[aidx(a)]);
    endtask

    task automatic model_trap(input int t, input logic [31:0] pc, input logic [31:0] cause);
        logic [31:0] st;
        push_evt(t + 1, c_EV_WR, 12'h341, pc);
        mdl_csr[2] = pc;
        push_evt(t + 2, c_EV_WR, 12'h342, cause);
        mdl_csr[3] = cause;
        st = 32'h0000_1800 | {24'h0, m_mie, 7'h0};
        push_evt(t + 3, c_EV_WR, 12'h300, st);
        mdl_csr[0] = st;
        m_mpie = m_mie;
        m_mie  = 1'b0;
        push_evt(t + 5, c_EV_RED, 12'h0, {mdl_csr[1][31:2], 2'b00});
        next_free = t + 6;
    endtask

    task automatic model_mret(input int t);
        logic [31:0] st;
        logic [31:0] tgt;
        tgt = mdl_csr[2];
        st  = 32'h0000_1880 | {28'h0, m_mpie, 3'h0};
        push_evt(t + 2, c_EV_WR, 12'h300, st);
        mdl_csr[0] = st;
        m_mie  = m_mpie;
        m_mpie = 1'b1;
        push_evt(t + 3, c_EV_RED, 12'h0, tgt);
        next_free = t + 4;
    endtask

    task automatic do_inst(input logic [2:0] k, input logic [31:0] pc, input bit irq);
        int t;
        quiet();
        inst_valid = 1'b1;
        inst_kind  = k;
        inst_pc    = pc;
        irq_timer  = irq;
        t = cyc;
        chk("inst_ready_at_issue", {31'h0, inst_ready}, 32'h1);
        if (irq && m_mie) begin
            push_evt(t, c_EV_SQ, 12'h0, 32'h0);
            model_trap(t, pc, 32'h8000_0007);
        end else if (k == 3'd2) model_trap(t, pc, 32'd11);
        else if (k == 3'd4)     model_trap(t, pc, 32'd2);
        else if (k == 3'd1)     model_mret(t);
        else                    next_free = t + 1;
    endtask

    initial begin
        int t;
        int kinds[7] = '{0, 1, 2, 4, 5, 6, 7};
        int sel;

        quiet();
        rst = 1'b1;
        repeat (3) tick();
        chk("rst_inst_ready", {31'h0, inst_ready}, 32'h1);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_halt", {31'h0, halt}, 32'h0);
        chk("rst_squash", {31'h0, squash}, 32'h0);
        chk("rst_redirect_valid", {31'h0, redirect_valid}, 32'h0);
        chk("rst_redirect_pc", redirect_pc, 32'h0);
        chk("rst_csr_wen", {31'h0, csr_wen}, 32'h0);
        rst = 1'b0;
        mon_en = 1'b1;
        next_free = cyc;

        // Directed scenarios
        advance(0); do_core_write(12'h305, 32'h8000_0203);
        advance(0); do_inst(3'd2, 32'h8000_0100, 1'b0);
        advance(2); do_core_write(12'h300, 32'h0000_0008);
        advance(0); do_inst(3'd0, 32'h8000_0040, 1'b1);
        advance(1); do_core_write(12'h341, 32'h8000_0044);
        advance(0); do_inst(3'd1, 32'h0000_0000, 1'b0);
        advance(1); do_inst(3'd0, 32'h8000_0080, 1'b1);
        advance(2); do_inst(3'd2, 32'h8000_00c0, 1'b1);
        advance(0); do_core_read(12'h342);
        advance(0); do_core_read(12'h300);

        // Randomized traffic
        for (int i = 0; i < 250; i++) begin
            advance(1);
            sel = $urandom_range(0, 9);
            if (sel < 3)       do_core_write(rand_addr(), $urandom());
            else if (sel == 3) do_core_read(rand_addr());
            else               do_inst(3'(kinds[$urandom_range(0, 6)]), $urandom(), $urandom_range(0, 2) == 0);
        end

        // Reset two cycles into a trap: only the first two writes may appear
        advance(0);
        quiet();
        inst_valid = 1'b1;
        inst_kind  = 3'd2;
        inst_pc    = 32'h8000_0400;
        t = cyc;
        push_evt(t + 1, c_EV_WR, 12'h341, 32'h8000_0400);
        push_evt(t + 2, c_EV_WR, 12'h342, 32'd11);
        mdl_csr[2] = 32'h8000_0400;
        mdl_csr[3] = 32'd11;
        tick(); quiet();
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        chk("abort_inst_ready", {31'h0, inst_ready}, 32'h1);
        chk("abort_busy", {31'h0, busy}, 32'h0);
        m_mie = 1'b0;
        m_mpie = 1'b0;
        next_free = cyc;
        repeat (8) advance(0);
        do_core_read(12'h342);

        // EBREAK parks the sequencer until reset
        advance(0); do_inst(3'd3, 32'h8000_0500, 1'b0);
        repeat (20) begin
            tick();
            junk();
            chk("halt_halt", {31'h0, halt}, 32'h1);
            chk("halt_busy", {31'h0, busy}, 32'h1);
            chk("halt_inst_ready", {31'h0, inst_ready}, 32'h0);
        end
        quiet();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("post_halt_halt", {31'h0, halt}, 32'h0);
        chk("post_halt_ready", {31'h0, inst_ready}, 32'h1);
        m_mie = 1'b0;
        m_mpie = 1'b0;
        next_free = cyc;
        advance(0); do_inst(3'd4, 32'h8000_0600, 1'b1);
        advance(0); quiet();
        repeat (3) tick();

        chk("queue_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
